// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between NUM_REQ byte sources, bounded bursts.
// Optional per-requester byte counters under `UART_TX_ARB_STATS_EN (adds stat_clr/stat_bytes).

`ifdef UART_TX_ARB_STATS_EN
module uart_tx_arb_stat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt_o
);
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt_q <= '0;
    else if (clr)                        cnt_q <= '0;
    else if (inc && cnt_q != 16'hFFFF)   cnt_q <= cnt_q + 16'd1;
  end

  assign cnt_o = cnt_q;
endmodule
`endif

module uart_tx_arbiter #(
  parameter  int NUM_REQ   = 2,
  parameter  int DATA_W    = 8,
  parameter  int BURST_MAX = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW        = $clog2(BURST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
`ifdef UART_TX_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*16-1:0]     stat_bytes
`endif
);
  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   g_q, g_d, ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   sel, idx, g_nxt;
  logic            found, g_vld, xfer;

  assign g_vld = req_valid[g_q];
  assign xfer  = (state_q == GRANT) && g_vld && tx_ready;
  assign g_nxt = (g_q == GW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;

  // First valid requester scanning upward from ptr, wrapping at NUM_REQ-1.
  always_comb begin
    sel   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = (idx == GW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (en && |req_valid) begin
          g_d     = sel;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        busy     = 1'b1;
        tx_valid = g_vld;
        tx_data  = req_data[g_q*DATA_W +: DATA_W];
        if (xfer) begin
          req_ready[g_q] = 1'b1;
          cnt_d          = cnt_q + 1'b1;
        end
        // A dropped valid means the requester finished its message.
        if (!g_vld || (xfer && cnt_q == CW'(BURST_MAX - 1))) begin
          state_d = IDLE;
          ptr_d   = g_nxt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_id = g_q;

`ifdef UART_TX_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    uart_tx_arb_stat_cnt u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stat_clr),
      .inc   (req_ready[i]),
      .cnt_o (stat_bytes[i*16 +: 16])
    );
  end
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: instance 0 with BURST_MAX=4, instance 1 with BURST_MAX=1.
module tb_uart_tx_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en        [2];
  logic [1:0] req_valid [2];
  logic [15:0] req_data [2];
  logic [1:0] req_ready [2];
  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       tx_ready  [2];
  logic       busy      [2];
  logic       grant_id  [2];
`ifdef UART_TX_ARB_STATS_EN
  logic       stat_clr  [2];
  logic [31:0] stat_bytes [2];
`endif

  int         n_chk = 0, n_fail = 0, cyc = 0;
  int         div   [2];
  int         xcnt  [2];
  logic [7:0] src_q [4][$];
  logic [11:0] exp_q [2][$];
  int         xt    [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .BURST_MAX(d == 0 ? 4 : 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[d]),
      .req_valid (req_valid[d]),
      .req_data  (req_data[d]),
      .req_ready (req_ready[d]),
      .tx_data   (tx_data[d]),
      .tx_valid  (tx_valid[d]),
      .tx_ready  (tx_ready[d]),
      .busy      (busy[d]),
      .grant_id  (grant_id[d])
`ifdef UART_TX_ARB_STATS_EN
      ,
      .stat_clr  (stat_clr[d]),
      .stat_bytes(stat_bytes[d])
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int d, input int i, input logic [7:0] b);
    src_q[d*2+i].push_back(b);
  endtask

  task automatic want(input int d, input int i, input logic [7:0] b);
    exp_q[d].push_back({4'(i), b});
  endtask

  task automatic wait_empty(input int d, input int budget);
    int n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q[d].size() != 0) begin
      chk("timeout_pending", exp_q[d].size(), 0);
      exp_q[d].delete();
    end
  endtask

  task automatic wait_xfers(input int d, input int target, input int budget);
    int n = 0;
    while (xcnt[d] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (xcnt[d] < target) chk("timeout_xfers", xcnt[d], target);
  endtask

  // Observes at negedge; requesters pop on req_ready and re-drive just after posedge.
  task automatic mon(input int d);
    logic       xfer;
    logic [1:0] rr;
    logic [11:0] e;
    forever begin
      @(negedge clk);
      xfer = 1'b0;
      rr   = '0;
      if (rst_n) begin
        xfer = tx_valid[d] & tx_ready[d];
        rr   = req_ready[d];
        if (xfer) begin
          xt[d].push_back(cyc);
          xcnt[d]++;
          if (exp_q[d].size() == 0) chk("unexpected_xfer", {4'(grant_id[d]), tx_data[d]}, 32'hFFFF);
          else begin
            e = exp_q[d].pop_front();
            chk("tx_byte", {4'(grant_id[d]), tx_data[d]}, e);
            chk("req_ready", rr, (e[11:8] == 4'd1) ? 2'b10 : 2'b01);
          end
        end else begin
          chk("req_ready_idle", rr, 0);
          if (!busy[d]) chk("idle_data", tx_data[d], 0);
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rr[i] && src_q[d*2+i].size() > 0) void'(src_q[d*2+i].pop_front());
        req_valid[d][i]       = src_q[d*2+i].size() > 0;
        req_data[d][i*8 +: 8] = (src_q[d*2+i].size() > 0) ? src_q[d*2+i][0] : 8'h00;
      end
      tx_ready[d] = (div[d] == 0) ? 1'b1 : (cyc % div[d] == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; tx_ready[d] = 1'b0; req_valid[d] = '0; req_data[d] = '0;
      div[d] = 0; xcnt[d] = 0;
`ifdef UART_TX_ARB_STATS_EN
      stat_clr[d] = 1'b0;
`endif
    end
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_req_ready", req_ready[0], 0);
    chk("rst_grant_id", grant_id[0], 0);
    chk("rst_tx_data", tx_data[0], 0);
    @(posedge clk); #3;
    rst_n = 1'b1; en[0] = 1'b1; en[1] = 1'b1;

    // Single requester, slow TX, release on valid drop.
    @(posedge clk); #2;
    div[0] = 10;
    put(0, 0, 8'h11); put(0, 0, 8'h22); put(0, 0, 8'h33);
    want(0, 0, 8'h11); want(0, 0, 8'h22); want(0, 0, 8'h33);
    wait_empty(0, 200);
    repeat (3) @(posedge clk); #2;
    chk("t1_busy_after", busy[0], 0);
    chk("t1_valid_after", tx_valid[0], 0);

    // ptr now 1: simultaneous requests grant requester 1 first.
    div[0] = 0;
    put(0, 0, 8'h71); put(0, 1, 8'h81);
    want(0, 1, 8'h81); want(0, 0, 8'h71);
    wait_empty(0, 50);
    repeat (3) @(posedge clk); #2;

    // Reset mid-burst.
    for (int k = 0; k < 4; k++) begin
      put(0, 0, 8'h40 + 8'(k)); put(0, 1, 8'h50 + 8'(k)); want(0, 1, 8'h50 + 8'(k));
    end
    wait_xfers(0, xcnt[0] + 2, 50);
    #2 chk("rst_mid_busy_before", busy[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_valid", tx_valid[0], 0);
    chk("rst_mid_busy", busy[0], 0);
    chk("rst_mid_req_ready", req_ready[0], 0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q[0].delete(); exp_q[1].delete();
    repeat (3) @(posedge clk); #3;
    rst_n = 1'b1;

    // Continuous streaming: blocks of 4, starting at requester 0, one bubble between.
    @(posedge clk); #2;
    xt[0].delete();
    for (int k = 0; k < 8; k++) begin
      put(0, 0, 8'hC0 + 8'(k)); put(0, 1, 8'hD0 + 8'(k));
    end
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        want(0, b % 2, ((b % 2) ? 8'hD0 : 8'hC0) + 8'((b / 2) * 4 + k));
    wait_empty(0, 200);
    chk("t2_xfer_count", xt[0].size(), 16);
    if (xt[0].size() == 16) chk("t2_span", xt[0][15] - xt[0][0], 18);

    // BURST_MAX=1: strict alternation.
    @(posedge clk); #2;
    div[1] = 0;
    xt[1].delete();
    for (int k = 0; k < 4; k++) begin
      put(1, 0, 8'h90 + 8'(k)); put(1, 1, 8'hA0 + 8'(k));
      want(1, 0, 8'h90 + 8'(k)); want(1, 1, 8'hA0 + 8'(k));
    end
    wait_empty(1, 100);
    chk("t3_xfer_count", xt[1].size(), 8);
    if (xt[1].size() == 8) chk("t3_span", xt[1][7] - xt[1][0], 14);

    // en low at byte 2 of 4: burst finishes, then no new grant.
    repeat (3) @(posedge clk); #2;
    div[0] = 3;
    for (int k = 0; k < 6; k++) begin
      put(0, 0, 8'hA0 + 8'(k)); put(0, 1, 8'hB0 + 8'(k));
    end
    for (int k = 0; k < 4; k++) want(0, 0, 8'hA0 + 8'(k));
    wait_xfers(0, xcnt[0] + 2, 50);
    #2 en[0] = 1'b0;
    wait_empty(0, 100);
    repeat (10) @(posedge clk); #2;
    chk("t4_busy_en_off", busy[0], 0);
    chk("t4_valid_en_off", tx_valid[0], 0);
    chk("t4_src0_left", src_q[0].size(), 2);
    chk("t4_src1_left", src_q[1].size(), 6);
    en[0] = 1'b1;
    for (int k = 0; k < 4; k++) want(0, 1, 8'hB0 + 8'(k));
    want(0, 0, 8'hA4); want(0, 0, 8'hA5);
    want(0, 1, 8'hB4); want(0, 1, 8'hB5);
    wait_empty(0, 300);

`ifdef UART_TX_ARB_STATS_EN
    repeat (3) @(posedge clk); #2;
    div[0] = 0;
    stat_clr[0] = 1'b1;
    @(posedge clk); #2;
    stat_clr[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(0, 1, 8'h60 + 8'(k)); want(0, 1, 8'h60 + 8'(k));
    end
    wait_empty(0, 100);
    repeat (3) @(posedge clk); #2;
    chk("stat_req1_five", stat_bytes[0][31:16], 5);
    chk("stat_req0_zero", stat_bytes[0][15:0], 0);
    stat_clr[0] = 1'b1;
    put(0, 1, 8'h6F); want(0, 1, 8'h6F);
    wait_empty(0, 50);
    repeat (2) @(posedge clk); #2;
    stat_clr[0] = 1'b0;
    @(posedge clk); #2;
    chk("stat_clr_wins", stat_bytes[0][31:16], 0);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
